logic_unit_arbiter: RTL and testbench

- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters.
- Arbitration is round-robin. Each requester has a valid/ready request channel; there is one valid/ready response channel.
- Operands and opcode are registered, the result is computed and returned with the requester ID, and per-requester completion counts are kept.
- Sits between the register-file read stage and write-back in the multi-cycle datapath.

---
 rtl/logic_unit_arbiter.sv | 127 ++++++++++++
 tb/tb_logic_unit_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_unit_arbiter: round-robin shared 32-bit AND/OR/XOR/NOR unit        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [WIDTH-1:0] w_result;

  // On contention the requester that did not win last time goes first.
  assign w_idle   = (r_state == S_IDLE);
  assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_accept = w_idle & (w_grant0 | w_grant1);

  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;

  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = r_a & r_b;
      2'b01:   w_result = r_a | r_b;
      2'b10:   w_result = r_a ^ r_b;
      default: w_result = ~(r_a | r_b);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_zero   <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op         <= w_grant1 ? req1_op : req0_op;
            r_a          <= w_grant1 ? req1_a  : req0_a;
            r_b          <= w_grant1 ? req1_b  : req0_b;
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= w_result;
          r_rsp_zero  <= (w_result == '0);
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_rsp_id) r_cnt1 <= r_cnt1 + CNT_W'(1);
            else          r_cnt0 <= r_cnt0 + CNT_W'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign done_cnt0 = r_cnt0;
  assign done_cnt1 = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_logic_unit_arbiter: directed bench, short counters to exercise wrap   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_logic_unit_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [1:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [WIDTH-1:0] rsp_data;
  logic [CNT_W-1:0] done_cnt0, done_cnt1;

  int n_total = 0;
  int n_pass  = 0;

  logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .done_cnt0  (done_cnt0),
    .done_cnt1  (done_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Bounded wait for a response, sampled on falling edges.
  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 2'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 2'd0; req1_a = '0; req1_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  rsp_data, 32'd0);
    check("rst_rsp_id",    32'(rsp_id), 32'd0);
    check("rst_rsp_zero",  32'(rsp_zero), 32'd0);
    check("rst_cnt0",      32'(done_cnt0), 32'd0);
    check("rst_cnt1",      32'(done_cnt1), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single AND from requester 0, exact latency
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00;
    @(negedge clk);
    check("t1_ready0", 32'(req0_ready), 32'd1);
    check("t1_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check("t1_exec_novalid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_data",  rsp_data, 32'hF000F000);
    check("t1_id",    32'(rsp_id), 32'd0);
    check("t1_zero",  32'(rsp_zero), 32'd0);
    @(negedge clk);
    check("t1_cnt0", 32'(done_cnt0), 32'd1);
    check("t1_valid_clr", 32'(rsp_valid), 32'd0);

    // Fresh reset so the pointer favours requester 0 again
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;

    // Both requesters valid continuously: grants alternate 0,1,0,1
    req0_op = 2'b10; req0_a = 32'h12345678; req0_b = 32'hFFFFFFFF;
    req1_op = 2'b01; req1_a = 32'h0;        req1_b = 32'h1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wait_rsp("t2_rsp_timeout");
      check("t2_id", 32'(rsp_id), 32'(i % 2));
      check("t2_data", rsp_data, (i % 2 == 0) ? 32'hEDCBA987 : 32'h00000001);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("t2_cnt0", 32'(done_cnt0), 32'd2);
    check("t2_cnt1", 32'(done_cnt1), 32'd2);

    // NOR to zero with back-pressure; inputs must be ignored in DONE
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'hFFFFFFFF; req1_b = 32'h0;
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp("t3_rsp_timeout");
    check("t3_data", rsp_data, 32'h0);
    check("t3_zero", 32'(rsp_zero), 32'd1);
    check("t3_id",   32'(rsp_id), 32'd1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(rsp_valid), 32'd1);
      check("t3_hold_data",  rsp_data, 32'h0);
      check("t3_hold_id",    32'(rsp_id), 32'd1);
      check("t3_hold_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      check("t3_hold_cnt1",  32'(done_cnt1), 32'd2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_cnt1", 32'(done_cnt1), 32'd3);
    check("t3_valid_clr", 32'(rsp_valid), 32'd0);

    // Asynchronous reset while holding a result in DONE
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 32'hFFFFFFFF; req1_b = 32'hFFFFFFFF;
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp("t4_rsp_timeout");
    check("t4_pre_data", rsp_data, 32'hFFFFFFFF);
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'hA5A5A5A5; req0_b = 32'hFFFF0000;
    req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_valid", 32'(rsp_valid), 32'd0);
    check("t4_async_data",  rsp_data, 32'h0);
    check("t4_async_cnt0",  32'(done_cnt0), 32'd0);
    check("t4_async_cnt1",  32'(done_cnt1), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_ready0", 32'(req0_ready), 32'd1);
    check("t4_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp("t4_rsp_timeout2");
    check("t4_id",   32'(rsp_id), 32'd0);
    check("t4_data", rsp_data, 32'h5A5AA5A5);
    @(negedge clk);
    check("t4_cnt0", 32'(done_cnt0), 32'd1);

    // Operands changed during EXEC must not affect the result
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h00000F00; req0_b = 32'h000000F0;
    @(posedge clk); #1
    req0_valid = 1'b0; req0_a = 32'hFFFFFFFF; req0_b = 32'hFFFFFFFF; req0_op = 2'b11;
    wait_rsp("t5_rsp_timeout");
    check("t5_data", rsp_data, 32'h00000FF0);
    @(negedge clk);
    check("t5_cnt0", 32'(done_cnt0), 32'd2);

    // Counter wrap with a 4-bit counter: 2 -> 15 -> 0
    for (int i = 1; i <= 14; i++) begin
      req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'(i); req0_b = 32'(i);
      @(posedge clk); #1 req0_valid = 1'b0;
      wait_rsp("t6_rsp_timeout");
      check("t6_data", rsp_data, 32'(i));
      @(negedge clk);
      if (i == 13) check("t6_cnt0_max", 32'(done_cnt0), 32'd15);
    end
    check("t6_cnt0_wrap", 32'(done_cnt0), 32'd0);
    check("t6_cnt1", 32'(done_cnt1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
